sum_rr_arbiter: RTL
===================

SUM_RR_ARBITER -- requirements
Module: sum_rr_arbiter

Interface
REQ-001 Parameter LEN, default 8: operand and result width.
REQ-002 Parameter N, default 4: number of requesters (2..8).
REQ-003 Parameter BURST, default 2: maximum consecutive beats granted to one requester (1..15).
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  N  per-requester operand-pair valid.
REQ-007 req_a  input  N*LEN  operand A; requester i occupies bits [i*LEN +: LEN].
REQ-008 req_b  input  N*LEN  operand B; same packing as req_a.
REQ-009 req_ready  output  N  per-requester accept, one-hot or zero.
REQ-010 out_valid  output  1  registered result valid.
REQ-011 out_data  output  LEN  registered sum, truncated to LEN bits.
REQ-012 out_id  output  clog2(N)  index of the requester that produced out_data.
REQ-013 out_ready  input  1  downstream accept.

Function
REQ-014 A transfer on requester i occurs when req_valid[i] and req_ready[i] are both 1 on a rising edge.
REQ-015 load_en = !out_valid || out_ready; req_ready is 0 for every requester when load_en is 0.
REQ-016 On a transfer from i, out_data <= req_a[i] + req_b[i] mod 2^LEN, out_id <= i, out_valid <= 1 the next cycle; latency 1 cycle.
REQ-017 When load_en is 1 and no transfer occurs, out_valid <= 0; when load_en is 0, out_valid, out_data and out_id hold.
REQ-018 State machine has two states: IDLE (no owner) and HOLD (owner register, beat counter cnt).
REQ-019 IDLE: winner is the first requester with req_valid set, searching from pointer ptr upward with wrap at N-1 to 0; req_ready[winner] = load_en.
REQ-020 IDLE, transfer, BURST > 1: go to HOLD, owner <= winner, cnt <= 1.
REQ-021 IDLE, transfer, BURST = 1: stay IDLE, ptr <= winner+1 mod N.
REQ-022 HOLD: only the owner is eligible; req_ready[owner] = load_en; transfer increments cnt.
REQ-023 HOLD, transfer bringing cnt to BURST: go to IDLE, ptr <= owner+1 mod N.
REQ-024 HOLD, req_valid[owner] = 0 and load_en = 1: go to IDLE, ptr <= owner+1 mod N, no grant that cycle (one bubble).
REQ-025 HOLD, load_en = 0: state, owner, cnt hold regardless of req_valid.
REQ-026 No requester valid in IDLE: state and ptr hold, req_ready = 0.

Reset
REQ-027 While rst is 1: out_valid = 0, out_data = 0, out_id = 0, req_ready = 0, state = IDLE, ptr = 0, cnt = 0, owner = 0.
REQ-028 Reset asserted mid-burst discards the held grant and the pending output; first grant after reset searches from requester 0.

Configuration
REQ-029 Macro SUM_RR_ARBITER_CARRY_EN defined: extra output out_carry (1 bit), registered with out_data, equal to bit LEN of the full sum, reset 0.
REQ-030 Macro undefined: port out_carry does not exist; the sum is truncated with no other change.

Structure
REQ-031 Shared package holds the state encoding (IDLE, HOLD) and an id-width constant function for clog2(N).
REQ-032 Sub-module rr_pick (N-wide request vector + start pointer -> winner index + any-valid flag) is the one natural sub-module; it is purely combinational.

Verification
REQ-033 Reset then req_valid=4'b0001, a0=3, b0=4, out_ready=1 -> next cycle out_valid=1, out_data=7, out_id=0.
REQ-034 All four valid continuously, BURST=2, out_ready=1 -> out_id sequence 0,0,1,1,2,2,3,3,0.
REQ-035 a=200, b=100, LEN=8 -> out_data=44; with SUM_RR_ARBITER_CARRY_EN, out_carry=1.
REQ-036 out_ready=0 with out_valid=1 for 3 cycles -> req_ready=0, out_data and out_id stable; accepted on release.
REQ-037 Owner 1 in HOLD drops req_valid, requester 2 valid -> one bubble cycle, then grant to 2.
REQ-038 rst pulsed in HOLD with out_valid=1 -> next cycle out_valid=0; first new grant goes to lowest-index valid requester.

Source files
------------

// File: rtl/sum_rr_arbiter_pkg.sv
// Shared types for the sum_rr_arbiter slice: arbiter state encoding and id-width helper.
package sum_rr_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  // Beat counter width covers the largest supported BURST (15).
  localparam int CNT_W = 4;

  function automatic int id_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/sum_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or after start, wrapping N-1 -> 0.
module rr_pick
  import sum_rr_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = id_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] winner,
  output logic          any
);

  logic [IW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(start) + k) % N);
      if (req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sum_rr_arbiter.sv
// Round-robin arbiter with burst hold feeding a registered adder (out = a + b mod 2^LEN).
// Optional carry output enabled by defining SUM_RR_ARBITER_CARRY_EN.
module sum_rr_arbiter
  import sum_rr_arbiter_pkg::*;
#(
  parameter int  LEN   = 8,
  parameter int  N     = 4,
  parameter int  BURST = 2,
  localparam int IW    = id_w(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  input  logic [N*LEN-1:0] req_a,
  input  logic [N*LEN-1:0] req_b,
  output logic [N-1:0]     req_ready,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [LEN-1:0]   out_data,
`ifdef SUM_RR_ARBITER_CARRY_EN
  output logic             out_carry,
`endif
  output logic [IW-1:0]    out_id
);

  function automatic logic [LEN:0] sum_full(input logic [LEN-1:0] a, input logic [LEN-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic logic [IW-1:0] nxt_id(input logic [IW-1:0] id);
    return (int'(id) == N - 1) ? '0 : id + 1'b1;
  endfunction

  arb_state_t       state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    owner;
  logic [CNT_W-1:0] cnt;

  logic [IW-1:0]    winner;
  logic [IW-1:0]    gnt_id;
  logic             any_vld;
  logic             load_en;
  logic             grant;
  logic             last_beat;
  logic [LEN-1:0]   a_arr [N];
  logic [LEN-1:0]   b_arr [N];
  logic [LEN:0]     sum_p0;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req    (req_valid),
    .start  (ptr),
    .winner (winner),
    .any    (any_vld)
  );

  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_arr[i] = req_a[i*LEN +: LEN];
      b_arr[i] = req_b[i*LEN +: LEN];
    end
  end

  assign load_en   = !out_valid || out_ready;
  assign last_beat = (cnt + 1'b1) == CNT_W'(BURST);

  // Stage p0: grant selection and operand sum.
  always_comb begin
    req_ready = '0;
    grant     = 1'b0;
    gnt_id    = winner;
    if (!rst) begin
      if (state == IDLE) begin
        if (any_vld) begin
          req_ready[winner] = load_en;
          grant             = load_en;
        end
      end else begin
        gnt_id           = owner;
        req_ready[owner] = load_en;
        grant            = load_en && req_valid[owner];
      end
    end
    sum_p0 = sum_full(a_arr[gnt_id], b_arr[gnt_id]);
  end

`ifndef SUM_RR_ARBITER_CARRY_EN
  logic unused_carry;
  assign unused_carry = sum_p0[LEN];
`endif

  // Stage p1: registered result and arbitration state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
`ifdef SUM_RR_ARBITER_CARRY_EN
      out_carry <= 1'b0;
`endif
    end else begin
      if (load_en) begin
        out_valid <= grant;
        if (grant) begin
          out_data  <= sum_p0[LEN-1:0];
          out_id    <= gnt_id;
`ifdef SUM_RR_ARBITER_CARRY_EN
          out_carry <= sum_p0[LEN];
`endif
        end
      end

      case (state)
        IDLE: begin
          if (grant) begin
            if (BURST > 1) begin
              state <= HOLD;
              owner <= winner;
              cnt   <= CNT_W'(1);
            end else begin
              ptr <= nxt_id(winner);
            end
          end
        end
        HOLD: begin
          // A dropped owner request ends the burst with a one-cycle bubble.
          if (load_en) begin
            if (!req_valid[owner] || last_beat) begin
              state <= IDLE;
              ptr   <= nxt_id(owner);
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
